// File: rtl/mc_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control unit.
//   - FSM state encoding and instruction class enum
//   - opcode / funct field constants
//   - datapath control codes (ALUOp, NPCOp, RegDst, MemtoReg, length, trap cause)
// The datapath control codes match the single-cycle decoder, so the
// datapath muxes are shared between the two controllers.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      CL_ALU_R  = 4'd0,
      CL_ALU_I  = 4'd1,
      CL_BRANCH = 4'd2,
      CL_LOAD   = 4'd3,
      CL_STORE  = 4'd4,
      CL_J      = 4'd5,
      CL_JAL    = 4'd6,
      CL_JR     = 4'd7,
      CL_JALR   = 4'd8
   } iclass_e;

   // opcodes
   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_SLTIU  = 6'b001011;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LH     = 6'b100001;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_LBU    = 6'b100100;
   localparam logic [5:0] OP_LHU    = 6'b100101;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SH     = 6'b101001;
   localparam logic [5:0] OP_SW     = 6'b101011;

   // R-type funct
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_SLLV = 6'b000100;
   localparam logic [5:0] F_SRLV = 6'b000110;
   localparam logic [5:0] F_SRAV = 6'b000111;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_JALR = 6'b001001;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;

   // REGIMM rt field
   localparam logic [4:0] RT_BLTZ = 5'b00000;
   localparam logic [4:0] RT_BGEZ = 5'b00001;

   // ALUOp; branch codes make the ALU raise Zero when the condition holds
   localparam logic [4:0] ALU_NOP  = 5'b00000;
   localparam logic [4:0] ALU_ADD  = 5'b00001;
   localparam logic [4:0] ALU_SUB  = 5'b00010;
   localparam logic [4:0] ALU_AND  = 5'b00011;
   localparam logic [4:0] ALU_OR   = 5'b00100;
   localparam logic [4:0] ALU_XOR  = 5'b00101;
   localparam logic [4:0] ALU_NOR  = 5'b00110;
   localparam logic [4:0] ALU_SLT  = 5'b00111;
   localparam logic [4:0] ALU_SLTU = 5'b01000;
   localparam logic [4:0] ALU_LUI  = 5'b01001;
   localparam logic [4:0] ALU_SLL  = 5'b01010;
   localparam logic [4:0] ALU_SRL  = 5'b01011;
   localparam logic [4:0] ALU_SRA  = 5'b01100;
   localparam logic [4:0] ALU_SLLV = 5'b01101;
   localparam logic [4:0] ALU_SRLV = 5'b01110;
   localparam logic [4:0] ALU_BGEZ = 5'b10000;
   localparam logic [4:0] ALU_BLTZ = 5'b10001;
   localparam logic [4:0] ALU_BLEZ = 5'b10010;
   localparam logic [4:0] ALU_BGTZ = 5'b10011;
   localparam logic [4:0] ALU_SRAV = 5'b10100;

   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   localparam logic [1:0] RD_RT  = 2'b00;
   localparam logic [1:0] RD_RD  = 2'b01;
   localparam logic [1:0] RD_R31 = 2'b10;

   localparam logic [1:0] M2R_ALU  = 2'b00;
   localparam logic [1:0] M2R_MEM  = 2'b01;
   localparam logic [1:0] M2R_LINK = 2'b10;

   // length: bit2 = unsigned load
   localparam logic [2:0] LEN_W  = 3'b000;
   localparam logic [2:0] LEN_H  = 3'b001;
   localparam logic [2:0] LEN_B  = 3'b010;
   localparam logic [2:0] LEN_HU = 3'b101;
   localparam logic [2:0] LEN_BU = 3'b110;

   localparam logic [1:0] TC_NONE    = 2'b00;
   localparam logic [1:0] TC_ILLEGAL = 2'b01;
   localparam logic [1:0] TC_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath/memory bundle.
//   master : the control unit (drives mem_req and all datapath controls)
//   slave  : datapath + memory (drives Instru, Zero, mem_ack)
interface mc_ctrl_if;
   logic [31:0] Instru;
   logic        Zero;
   logic        mem_ack;
   logic        mem_req;
   logic        PCWrite;
   logic        IRWrite;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        EXTOp;
   logic        ALUSrc;
   logic        ALUSrc2;
   logic [1:0]  RegDst;
   logic [1:0]  MemtoReg;
   logic [4:0]  ALUOp;
   logic [1:0]  NPCOp;
   logic [2:0]  length;
   logic        trap;
   logic [1:0]  trap_cause;

   modport master (
      input  Instru, Zero, mem_ack,
      output mem_req, PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
             EXTOp, ALUSrc, ALUSrc2, RegDst, MemtoReg, ALUOp, NPCOp,
             length, trap, trap_cause
   );

   modport slave (
      output Instru, Zero, mem_ack,
      input  mem_req, PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
             EXTOp, ALUSrc, ALUSrc2, RegDst, MemtoReg, ALUOp, NPCOp,
             length, trap, trap_cause
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational instruction classifier.
//   i_instru    : instruction word from the IR
//   o_iclass    : instruction class (ALU-R/I, branch, load, store, jumps)
//   o_is_bne    : branch is taken on !Zero instead of Zero
//   o_alu_op    : ALUOp code, o_alu_src / o_alu_src2 / o_ext_op operand selects
//   o_length    : memory access size for loads/stores
//   o_illegal   : unknown opcode/funct
// Macro CTRL_SUBWORD_EN enables lb/lbu/lh/lhu/sb/sh; without it they are illegal.
module mc_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  logic [31:0] i_instru,
   output iclass_e     o_iclass,
   output logic        o_is_bne,
   output logic [4:0]  o_alu_op,
   output logic        o_alu_src,
   output logic        o_alu_src2,
   output logic        o_ext_op,
   output logic [2:0]  o_length,
   output logic        o_illegal
);

   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic [4:0] w_rt;
   logic       w_unused;

   assign w_op     = i_instru[31:26];
   assign w_funct  = i_instru[5:0];
   assign w_rt     = i_instru[20:16];
   assign w_unused = ^{i_instru[25:21], i_instru[15:6]};

   always_comb begin
      o_iclass   = CL_ALU_R;
      o_is_bne   = 1'b0;
      o_alu_op   = ALU_NOP;
      o_alu_src  = 1'b0;
      o_alu_src2 = 1'b0;
      o_ext_op   = 1'b0;
      o_length   = LEN_W;
      o_illegal  = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            case (w_funct)
               F_ADD, F_ADDU: o_alu_op = ALU_ADD;
               F_SUB, F_SUBU: o_alu_op = ALU_SUB;
               F_AND:         o_alu_op = ALU_AND;
               F_OR:          o_alu_op = ALU_OR;
               F_XOR:         o_alu_op = ALU_XOR;
               F_NOR:         o_alu_op = ALU_NOR;
               F_SLT:         o_alu_op = ALU_SLT;
               F_SLTU:        o_alu_op = ALU_SLTU;
               // ALUSrc2 selects shamt as the shift amount
               F_SLL: begin o_alu_op = ALU_SLL; o_alu_src2 = 1'b1; end
               F_SRL: begin o_alu_op = ALU_SRL; o_alu_src2 = 1'b1; end
               F_SRA: begin o_alu_op = ALU_SRA; o_alu_src2 = 1'b1; end
               F_SLLV:        o_alu_op = ALU_SLLV;
               F_SRLV:        o_alu_op = ALU_SRLV;
               F_SRAV:        o_alu_op = ALU_SRAV;
               F_JR:          o_iclass = CL_JR;
               F_JALR:        o_iclass = CL_JALR;
               default:       o_illegal = 1'b1;
            endcase
         end
         OP_REGIMM: begin
            o_iclass = CL_BRANCH;
            case (w_rt)
               RT_BGEZ: o_alu_op = ALU_BGEZ;
               RT_BLTZ: o_alu_op = ALU_BLTZ;
               default: o_illegal = 1'b1;
            endcase
         end
         OP_BEQ:  begin o_iclass = CL_BRANCH; o_alu_op = ALU_SUB; end
         OP_BNE:  begin o_iclass = CL_BRANCH; o_alu_op = ALU_SUB; o_is_bne = 1'b1; end
         OP_BLEZ: begin o_iclass = CL_BRANCH; o_alu_op = ALU_BLEZ; end
         OP_BGTZ: begin o_iclass = CL_BRANCH; o_alu_op = ALU_BGTZ; end
         OP_ADDI, OP_ADDIU: begin
            o_iclass = CL_ALU_I; o_alu_op = ALU_ADD; o_alu_src = 1'b1; o_ext_op = 1'b1;
         end
         OP_SLTI: begin
            o_iclass = CL_ALU_I; o_alu_op = ALU_SLT; o_alu_src = 1'b1; o_ext_op = 1'b1;
         end
         OP_SLTIU: begin
            o_iclass = CL_ALU_I; o_alu_op = ALU_SLTU; o_alu_src = 1'b1; o_ext_op = 1'b1;
         end
         // logical immediates are zero-extended
         OP_ANDI: begin o_iclass = CL_ALU_I; o_alu_op = ALU_AND; o_alu_src = 1'b1; end
         OP_ORI:  begin o_iclass = CL_ALU_I; o_alu_op = ALU_OR;  o_alu_src = 1'b1; end
         OP_XORI: begin o_iclass = CL_ALU_I; o_alu_op = ALU_XOR; o_alu_src = 1'b1; end
         OP_LUI:  begin o_iclass = CL_ALU_I; o_alu_op = ALU_LUI; o_alu_src = 1'b1; end
         OP_LW: begin
            o_iclass = CL_LOAD; o_alu_op = ALU_ADD; o_alu_src = 1'b1; o_ext_op = 1'b1;
         end
         OP_SW: begin
            o_iclass = CL_STORE; o_alu_op = ALU_ADD; o_alu_src = 1'b1; o_ext_op = 1'b1;
         end
`ifdef CTRL_SUBWORD_EN
         OP_LB, OP_LBU, OP_LH, OP_LHU: begin
            o_iclass = CL_LOAD; o_alu_op = ALU_ADD; o_alu_src = 1'b1; o_ext_op = 1'b1;
            case (w_op)
               OP_LB:   o_length = LEN_B;
               OP_LBU:  o_length = LEN_BU;
               OP_LH:   o_length = LEN_H;
               default: o_length = LEN_HU;
            endcase
         end
         OP_SB, OP_SH: begin
            o_iclass = CL_STORE; o_alu_op = ALU_ADD; o_alu_src = 1'b1; o_ext_op = 1'b1;
            o_length = (w_op == OP_SB) ? LEN_B : LEN_H;
         end
`endif
         OP_J:    o_iclass = CL_J;
         OP_JAL:  o_iclass = CL_JAL;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the MIPS CPU.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset (deasserted synchronously by the system)
//   bus  : mc_ctrl_if.master -- Instru/Zero/mem_ack in, memory request and
//          datapath controls out, sticky trap + trap_cause out
// Parameters: MEM_TIMEOUT (1..255) cycles without mem_ack before a timeout
// trap; TO_W counter width (MEM_TIMEOUT < 2**TO_W).
// Macro CTRL_SUBWORD_EN (in mc_ctrl_decode) enables sub-word loads/stores.
//
// state  | meaning
// IDLE   | after reset, no outputs, moves to FETCH
// FETCH  | read instruction; on ack load IR and PC+4
// DECODE | classify; jumps complete here, illegal -> TRAP
// EXEC   | ALU operation; branches resolve here
// MEM    | data load/store handshake
// WB     | register file write
// TRAP   | halted until reset; trap/trap_cause reported
module mc_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 8
)(
   input  logic      clk,
   input  logic      rstn,
   mc_ctrl_if.master bus
);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_FETCH  = ST_FETCH;
   localparam logic [2:0] S_DECODE = ST_DECODE;
   localparam logic [2:0] S_EXEC   = ST_EXEC;
   localparam logic [2:0] S_MEM    = ST_MEM;
   localparam logic [2:0] S_WB     = ST_WB;
   localparam logic [2:0] S_TRAP   = ST_TRAP;

   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic [TO_W-1:0] r_to_cnt;
   logic          r_trap;
   logic [1:0]    r_trap_cause;
   logic          w_trap_set;
   logic [1:0]    w_cause_nxt;

   iclass_e       w_iclass;
   logic          w_is_bne;
   logic [4:0]    w_dec_alu_op;
   logic          w_dec_alu_src;
   logic          w_dec_alu_src2;
   logic          w_dec_ext_op;
   logic [2:0]    w_dec_length;
   logic          w_illegal;
   logic          w_to_limit;
   logic          w_br_take;

   logic          w_mem_req, w_mem_read, w_mem_write;
   logic          w_pc_write, w_ir_write, w_reg_write;
   logic          w_ext_op, w_alu_src, w_alu_src2;
   logic [1:0]    w_reg_dst, w_mem_to_reg, w_npc_op;
   logic [4:0]    w_alu_op;
   logic [2:0]    w_length;

   mc_ctrl_decode u_decode (
      .i_instru   (bus.Instru),
      .o_iclass   (w_iclass),
      .o_is_bne   (w_is_bne),
      .o_alu_op   (w_dec_alu_op),
      .o_alu_src  (w_dec_alu_src),
      .o_alu_src2 (w_dec_alu_src2),
      .o_ext_op   (w_dec_ext_op),
      .o_length   (w_dec_length),
      .o_illegal  (w_illegal)
   );

   // limit is reached on the MEM_TIMEOUT-th unacknowledged request cycle
   assign w_to_limit = (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));
   assign w_br_take  = w_is_bne ? ~bus.Zero : bus.Zero;

   always_comb begin
      w_state_nxt  = r_state;
      w_trap_set   = 1'b0;
      w_cause_nxt  = TC_NONE;
      w_mem_req    = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_pc_write   = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_ext_op     = 1'b0;
      w_alu_src    = 1'b0;
      w_alu_src2   = 1'b0;
      w_reg_dst    = RD_RT;
      w_mem_to_reg = M2R_ALU;
      w_npc_op     = NPC_PC4;
      w_alu_op     = ALU_NOP;
      w_length     = LEN_W;
      case (r_state)
         S_IDLE: w_state_nxt = S_FETCH;
         S_FETCH: begin
            w_mem_req  = 1'b1;
            w_mem_read = 1'b1;
            if (bus.mem_ack) begin
               w_ir_write  = 1'b1;
               w_pc_write  = 1'b1;
               w_npc_op    = NPC_PC4;
               w_state_nxt = S_DECODE;
            end else if (w_to_limit) begin
               w_trap_set  = 1'b1;
               w_cause_nxt = TC_TIMEOUT;
               w_state_nxt = S_TRAP;
            end
         end
         S_DECODE: begin
            if (w_illegal) begin
               w_trap_set  = 1'b1;
               w_cause_nxt = TC_ILLEGAL;
               w_state_nxt = S_TRAP;
            end else begin
               case (w_iclass)
                  CL_J, CL_JAL: begin
                     w_pc_write  = 1'b1;
                     w_npc_op    = NPC_J;
                     w_state_nxt = S_FETCH;
                     if (w_iclass == CL_JAL) begin
                        w_reg_write  = 1'b1;
                        w_reg_dst    = RD_R31;
                        w_mem_to_reg = M2R_LINK;
                     end
                  end
                  CL_JR, CL_JALR: begin
                     w_pc_write  = 1'b1;
                     w_npc_op    = NPC_JR;
                     w_state_nxt = S_FETCH;
                     if (w_iclass == CL_JALR) begin
                        w_reg_write  = 1'b1;
                        w_reg_dst    = RD_RD;
                        w_mem_to_reg = M2R_LINK;
                     end
                  end
                  default: w_state_nxt = S_EXEC;
               endcase
            end
         end
         S_EXEC: begin
            w_alu_op   = w_dec_alu_op;
            w_alu_src  = w_dec_alu_src;
            w_alu_src2 = w_dec_alu_src2;
            w_ext_op   = w_dec_ext_op;
            case (w_iclass)
               CL_BRANCH: begin
                  w_pc_write  = w_br_take;
                  w_npc_op    = w_br_take ? NPC_BR : NPC_PC4;
                  w_state_nxt = S_FETCH;
               end
               CL_LOAD, CL_STORE: w_state_nxt = S_MEM;
               default:           w_state_nxt = S_WB;
            endcase
         end
         S_MEM: begin
            w_alu_op    = w_dec_alu_op;
            w_alu_src   = w_dec_alu_src;
            w_alu_src2  = w_dec_alu_src2;
            w_ext_op    = w_dec_ext_op;
            w_mem_req   = 1'b1;
            w_mem_read  = (w_iclass == CL_LOAD);
            w_mem_write = (w_iclass == CL_STORE);
            w_length    = w_dec_length;
            if (bus.mem_ack) begin
               w_state_nxt = (w_iclass == CL_LOAD) ? S_WB : S_FETCH;
            end else if (w_to_limit) begin
               w_trap_set  = 1'b1;
               w_cause_nxt = TC_TIMEOUT;
               w_state_nxt = S_TRAP;
            end
         end
         S_WB: begin
            w_reg_write = 1'b1;
            w_state_nxt = S_FETCH;
            if (w_iclass == CL_LOAD) begin
               w_mem_to_reg = M2R_MEM;
               w_length     = w_dec_length;
            end
            w_reg_dst = (w_iclass == CL_ALU_R) ? RD_RD : RD_RT;
         end
         S_TRAP:  w_state_nxt = S_TRAP;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // cleared on entering a request state and on every accepted request
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_to_cnt <= '0;
      end else if (((w_state_nxt == S_FETCH) || (w_state_nxt == S_MEM)) && (w_state_nxt != r_state)) begin
         r_to_cnt <= '0;
      end else if (w_mem_req && bus.mem_ack) begin
         r_to_cnt <= '0;
      end else if (w_mem_req) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_trap       <= 1'b0;
         r_trap_cause <= TC_NONE;
      end else if (w_trap_set) begin
         r_trap       <= 1'b1;
         r_trap_cause <= w_cause_nxt;
      end
   end

   assign bus.mem_req    = w_mem_req;
   assign bus.MemRead    = w_mem_read;
   assign bus.MemWrite   = w_mem_write;
   assign bus.PCWrite    = w_pc_write;
   assign bus.IRWrite    = w_ir_write;
   assign bus.RegWrite   = w_reg_write;
   assign bus.EXTOp      = w_ext_op;
   assign bus.ALUSrc     = w_alu_src;
   assign bus.ALUSrc2    = w_alu_src2;
   assign bus.RegDst     = w_reg_dst;
   assign bus.MemtoReg   = w_mem_to_reg;
   assign bus.NPCOp      = w_npc_op;
   assign bus.ALUOp      = w_alu_op;
   assign bus.length     = w_length;
   assign bus.trap       = r_trap;
   assign bus.trap_cause = r_trap_cause;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
   import mips_ctrl_pkg::*;

   localparam logic [31:0] I_ADDU = 32'h00221821;
   localparam logic [31:0] I_LW   = 32'h8C220004;
   localparam logic [31:0] I_SW   = 32'hAC220004;
   localparam logic [31:0] I_BEQ  = 32'h10220003;
   localparam logic [31:0] I_BNE  = 32'h14220003;
   localparam logic [31:0] I_JAL  = 32'h0C000010;
   localparam logic [31:0] I_J    = 32'h08000000;
   localparam logic [31:0] I_ORI  = 32'h34220005;
   localparam logic [31:0] I_LB   = 32'h80220000;
   localparam logic [31:0] I_BAD  = 32'hFC000000;

   logic clk = 1'b0;
   logic rstn;
   int   checks   = 0;
   int   failures = 0;

   mc_ctrl_if bus();

   mc_ctrl #(.MEM_TIMEOUT(15), .TO_W(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic st(input string tag, input state_e s);
      ck(tag, {29'd0, dut.r_state}, {29'd0, s});
   endtask

   // drive inputs mid-cycle, then settle before checking
   task automatic cyc(input logic [31:0] ins, input logic z, input logic ack);
      @(negedge clk);
      bus.Instru  = ins;
      bus.Zero    = z;
      bus.mem_ack = ack;
      #1;
   endtask

   initial begin
      rstn        = 1'b0;
      bus.Instru  = '0;
      bus.Zero    = 1'b0;
      bus.mem_ack = 1'b0;

      // reset state
      cyc(0, 0, 1);
      st("rst_state", ST_IDLE);
      ck("rst_mem_req", bus.mem_req, 0);
      ck("rst_trap", bus.trap, 0);
      ck("rst_cause", bus.trap_cause, 0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      ck("rel_no_req", bus.mem_req, 0);

      // addu: FETCH, DECODE, EXEC, WB
      cyc(I_ADDU, 0, 1);
      st("addu_f", ST_FETCH);
      ck("addu_f_req", bus.mem_req, 1);
      ck("addu_f_rd", bus.MemRead, 1);
      ck("addu_f_irw", bus.IRWrite, 1);
      ck("addu_f_pcw", bus.PCWrite, 1);
      ck("addu_f_npc", bus.NPCOp, 2'b00);
      cyc(I_ADDU, 0, 0);
      st("addu_d", ST_DECODE);
      ck("addu_d_pcw", bus.PCWrite, 0);
      ck("addu_d_irw", bus.IRWrite, 0);
      cyc(I_ADDU, 0, 1);
      st("addu_e", ST_EXEC);
      ck("addu_e_aluop", bus.ALUOp, 5'b00001);
      ck("addu_e_alusrc", bus.ALUSrc, 0);
      ck("addu_e_req", bus.mem_req, 0);
      cyc(I_ADDU, 0, 0);
      st("addu_w", ST_WB);
      ck("addu_w_rw", bus.RegWrite, 1);
      ck("addu_w_dst", bus.RegDst, 2'b01);
      ck("addu_w_m2r", bus.MemtoReg, 2'b00);

      // lw with three wait cycles in MEM: 8 cycles
      cyc(I_LW, 0, 1);
      st("lw_f", ST_FETCH);
      ck("lw_f_rw", bus.RegWrite, 0);
      cyc(I_LW, 0, 0);
      st("lw_d", ST_DECODE);
      cyc(I_LW, 0, 0);
      st("lw_e", ST_EXEC);
      ck("lw_e_aluop", bus.ALUOp, 5'b00001);
      ck("lw_e_alusrc", bus.ALUSrc, 1);
      ck("lw_e_ext", bus.EXTOp, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(I_LW, 0, 0);
         st("lw_m_wait", ST_MEM);
         ck("lw_m_req", bus.mem_req, 1);
         ck("lw_m_rd", bus.MemRead, 1);
      end
      cyc(I_LW, 0, 1);
      st("lw_m_ack", ST_MEM);
      ck("lw_m_wr", bus.MemWrite, 0);
      ck("lw_m_len", bus.length, 3'b000);
      cyc(I_LW, 0, 0);
      st("lw_w", ST_WB);
      ck("lw_w_rw", bus.RegWrite, 1);
      ck("lw_w_m2r", bus.MemtoReg, 2'b01);
      ck("lw_w_dst", bus.RegDst, 2'b00);

      // beq taken
      cyc(I_BEQ, 0, 1);
      st("beq1_f", ST_FETCH);
      ck("beq1_f_rw", bus.RegWrite, 0);
      cyc(I_BEQ, 0, 0);
      cyc(I_BEQ, 1, 0);
      st("beq1_e", ST_EXEC);
      ck("beq1_e_pcw", bus.PCWrite, 1);
      ck("beq1_e_npc", bus.NPCOp, 2'b01);
      ck("beq1_e_aluop", bus.ALUOp, 5'b00010);
      // beq not taken
      cyc(I_BEQ, 0, 1);
      st("beq0_f", ST_FETCH);
      cyc(I_BEQ, 0, 0);
      cyc(I_BEQ, 0, 0);
      st("beq0_e", ST_EXEC);
      ck("beq0_e_pcw", bus.PCWrite, 0);
      // bne with Zero=0 is taken
      cyc(I_BNE, 0, 1);
      st("bne_f", ST_FETCH);
      cyc(I_BNE, 0, 0);
      cyc(I_BNE, 0, 0);
      ck("bne_e_pcw", bus.PCWrite, 1);
      ck("bne_e_npc", bus.NPCOp, 2'b01);

      // jal: completes in DECODE
      cyc(I_JAL, 0, 1);
      st("jal_f", ST_FETCH);
      cyc(I_JAL, 0, 0);
      st("jal_d", ST_DECODE);
      ck("jal_d_pcw", bus.PCWrite, 1);
      ck("jal_d_npc", bus.NPCOp, 2'b10);
      ck("jal_d_rw", bus.RegWrite, 1);
      ck("jal_d_dst", bus.RegDst, 2'b10);
      ck("jal_d_m2r", bus.MemtoReg, 2'b10);

      // sw: FETCH, DECODE, EXEC, MEM then FETCH
      cyc(I_SW, 0, 1);
      st("sw_f", ST_FETCH);
      ck("sw_f_rw", bus.RegWrite, 0);
      cyc(I_SW, 0, 0);
      cyc(I_SW, 0, 0);
      st("sw_e", ST_EXEC);
      cyc(I_SW, 0, 1);
      st("sw_m", ST_MEM);
      ck("sw_m_wr", bus.MemWrite, 1);
      ck("sw_m_rd", bus.MemRead, 0);
      ck("sw_m_req", bus.mem_req, 1);

      // ori: zero-extended immediate, writes rt
      cyc(I_ORI, 0, 1);
      st("ori_f", ST_FETCH);
      cyc(I_ORI, 0, 0);
      cyc(I_ORI, 0, 0);
      st("ori_e", ST_EXEC);
      ck("ori_e_alusrc", bus.ALUSrc, 1);
      ck("ori_e_ext", bus.EXTOp, 0);
      cyc(I_ORI, 0, 0);
      st("ori_w", ST_WB);
      ck("ori_w_dst", bus.RegDst, 2'b00);
      ck("ori_w_rw", bus.RegWrite, 1);

      // ack in the same cycle as the timeout limit wins
      for (int i = 0; i < 14; i++) begin
         cyc(I_J, 0, 0);
         st("lim_wait", ST_FETCH);
      end
      cyc(I_J, 0, 1);
      st("lim_ack_f", ST_FETCH);
      ck("lim_ack_irw", bus.IRWrite, 1);
      cyc(I_J, 0, 0);
      st("lim_ack_d", ST_DECODE);
      ck("lim_ack_trap", bus.trap, 0);
      ck("j_d_npc", bus.NPCOp, 2'b10);
      ck("j_d_rw", bus.RegWrite, 0);

      // fetch timeout: 15 unacknowledged cycles then TRAP
      for (int i = 0; i < 15; i++) begin
         cyc(0, 0, 0);
         st("to_wait", ST_FETCH);
         ck("to_wait_trap", bus.trap, 0);
      end
      cyc(0, 0, 0);
      st("to_trap", ST_TRAP);
      ck("to_trap_flag", bus.trap, 1);
      ck("to_trap_cause", bus.trap_cause, 2'b10);
      ck("to_trap_req", bus.mem_req, 0);
      cyc(I_ADDU, 1, 1);
      st("to_trap_hold", ST_TRAP);
      ck("to_trap_hold_cause", bus.trap_cause, 2'b10);
      ck("to_trap_hold_pcw", bus.PCWrite, 0);
      // reset mid-cycle while trapped
      rstn = 1'b0;
      #1;
      st("trap_rst_state", ST_IDLE);
      ck("trap_rst_flag", bus.trap, 0);
      ck("trap_rst_cause", bus.trap_cause, 2'b00);
      ck("trap_rst_req", bus.mem_req, 0);
      @(negedge clk);
      rstn = 1'b1;

      // lb: sub-word load or illegal depending on build
      cyc(I_LB, 0, 1);
      st("lb_f", ST_FETCH);
      cyc(I_LB, 0, 0);
      st("lb_d", ST_DECODE);
`ifdef CTRL_SUBWORD_EN
      cyc(I_LB, 0, 0);
      st("lb_e", ST_EXEC);
      cyc(I_LB, 0, 1);
      st("lb_m", ST_MEM);
      ck("lb_m_len", bus.length, 3'b010);
      ck("lb_m_rd", bus.MemRead, 1);
      cyc(I_LB, 0, 0);
      st("lb_w", ST_WB);
      ck("lb_w_len", bus.length, 3'b010);
      ck("lb_w_m2r", bus.MemtoReg, 2'b01);
`else
      cyc(I_LB, 0, 0);
      st("lb_trap", ST_TRAP);
      ck("lb_trap_cause", bus.trap_cause, 2'b01);
      ck("lb_trap_flag", bus.trap, 1);
`endif

      // unknown opcode traps in either build
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      cyc(I_BAD, 0, 1);
      st("bad_f", ST_FETCH);
      cyc(I_BAD, 0, 0);
      st("bad_d", ST_DECODE);
      ck("bad_d_pcw", bus.PCWrite, 0);
      cyc(I_BAD, 0, 0);
      st("bad_trap", ST_TRAP);
      ck("bad_trap_cause", bus.trap_cause, 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
